input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//  Front-end conditioning stage for the pill-dispensing controller: synchronises and debounces the
//  16 keyboard keys, 5 push buttons and the pill-drop sensor. Emits one-cycle press/drop pulses
//  (keyboard_down, button_down, pill_pulse) consumed by the state machine, pointer and data logic.
//  Runs on the controller's phase-0 timing clock; all cycle counts below are counts of that clock.
// PARAMETERS
//  DEBOUNCE_CYCLES   20    consecutive stable samples required to accept a key/button level change
//  PILL_FILTER_CYCLES 3    consecutive stable samples required to accept a pill sensor change
//  REPEAT_DELAY      500   hold time before first auto-repeat (used only with BUTTON_AUTO_REPEAT_EN)
//  REPEAT_PERIOD     100   interval between auto-repeat pulses (used only with BUTTON_AUTO_REPEAT_EN)
// PORTS
//  clock          in   1   timing clock (rising edge)
//  reset_n        in   1   asynchronous active-low reset
//  keyboard       in   16  raw key levels, 1 = pressed, asynchronous to clock
//  button         in   5   raw button levels, 1 = pressed, asynchronous
//  pill           in   1   raw pill sensor, 1 = pill present in beam, asynchronous
//  keyboard_down  out  16  one-cycle pulse per accepted key press, bit i <-> keyboard[i]
//  button_down    out  5   one-cycle pulse per accepted button press (and repeats, if enabled)
//  pill_pulse     out  1   one-cycle pulse per accepted pill (rising edge of filtered sensor)
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs 0; synchroniser flops, filtered levels, counters cleared.
//  - Every input bit: 2-flop synchroniser -> per-bit stability counter -> filtered level register.
//  - Counter: sync value == filtered level -> counter cleared to 0; differs -> counter increments;
//    reaching DEBOUNCE_CYCLES (PILL_FILTER_CYCLES for pill) -> filtered level takes sync value,
//    counter cleared. Any single-cycle disagreement resets the count (glitch rejected).
//  - Pulse output registered: asserts for exactly 1 cycle on filtered 0->1; never on 1->0.
//  - Latency: raw high first sampled at edge k, held stable -> pulse high in cycle
//    k+2+DEBOUNCE_CYCLES (k+2+PILL_FILTER_CYCLES for pill), low the next cycle.
//  - Counter width: $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)+1); saturates, no wrap.
//  - Bits are independent: simultaneous presses produce pulses on all affected bits same cycle.
//  - A level held across reset release is treated as a new press: pulse after normal latency.
//  - Reset asserted mid-debounce discards partial counts; no pulse is emitted for that event.
//  - Release shorter than DEBOUNCE_CYCLES between two presses -> single pulse only.
// CONFIGURATION
//  BUTTON_AUTO_REPEAT_EN defined: per-button hold counter starts on accepted press; at REPEAT_DELAY
//    cycles after the press pulse a repeat pulse issues, then one every REPEAT_PERIOD cycles while
//    filtered level stays 1; release (filtered 1->0) clears the hold counter immediately.
//  BUTTON_AUTO_REPEAT_EN undefined: hold counters not built; a held button yields exactly one
//    pulse. keyboard_down and pill_pulse never repeat in either build.
// TESTING
//  1. keyboard[5] 0->1 held 40 cycles, DEBOUNCE_CYCLES=20 -> keyboard_down=16'h0020 for one cycle
//     exactly 22 cycles after first high sample; all other bits 0 throughout.
//  2. button[3] bounces (high 5, low 2, high 5, low 3) then held high 30 -> one button_down[3] pulse,
//     timed 22 cycles after the final stable rise; none during bounce.
//  3. pill high 2 cycles then low (PILL_FILTER_CYCLES=3) -> no pill_pulse; pill high 4 cycles ->
//     one pill_pulse 5 cycles after rise; ten 6-cycle pills spaced 6 cycles apart -> ten pulses.
//  4. keyboard[0], keyboard[15], button[0] rise same edge -> all three pulses in the same cycle.
//  5. keyboard[2] high 15 cycles, reset_n low 1 cycle, held high after -> outputs 0 during reset,
//     single pulse 22 cycles after reset release.
//  6. BUTTON_AUTO_REPEAT_EN, button[1] held 800 cycles, REPEAT_DELAY=500, PERIOD=100 -> pulses at
//     press, +500, +600, +700 cycles; without the macro -> only the press pulse.

Source files
------------

// File: rtl/input_debouncer.sv
// Synchroniser + debounce filter for 16 keys, 5 buttons and the pill sensor, emitting one-cycle press pulses.
// Optional button auto-repeat is built when BUTTON_AUTO_REPEAT_EN is defined.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES    = 20,
  parameter int PILL_FILTER_CYCLES = 3,
  parameter int REPEAT_DELAY       = 500,
  parameter int REPEAT_PERIOD      = 100
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] keyboard,
  input  logic [4:0]  button,
  input  logic        pill,
  output logic [15:0] keyboard_down,
  output logic [4:0]  button_down,
  output logic        pill_pulse
);

  localparam int NB       = 22;
  localparam int PILL_BIT = 21;
  localparam int MAX_AB   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ABC  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int MAXC     = (MAX_ABC > PILL_FILTER_CYCLES) ? MAX_ABC : PILL_FILTER_CYCLES;
  localparam int CW       = $clog2(MAXC + 1);

  localparam logic [CW-1:0] KEY_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] PILL_LAST = CW'(PILL_FILTER_CYCLES - 1);

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1, sync2, filt, filt_prev, rise;
  logic [CW-1:0] cnt [NB];

  assign raw = {pill, button, keyboard};

  // Counter tracks consecutive samples that disagree with the filtered level;
  // the level flips on the last of those samples, and the pulse follows one edge later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      filt      <= '0;
      filt_prev <= '0;
      rise      <= '0;
      for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      filt_prev <= filt;
      rise      <= filt & ~filt_prev;
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == ((i == PILL_BIT) ? PILL_LAST : KEY_LAST)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else if (cnt[i] != '1) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign keyboard_down = rise[15:0];
  assign pill_pulse    = rise[PILL_BIT];

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] hcnt [5];
  logic [4:0]    first;
  logic [4:0]    rep;

  // hcnt is re-aligned to 1 the cycle after the press pulse, so hcnt==j means j cycles since it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      first <= '1;
      rep   <= '0;
      for (int unsigned i = 0; i < 5; i++) hcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        rep[i] <= 1'b0;
        if (!filt[16+i]) begin
          hcnt[i]  <= '0;
          first[i] <= 1'b1;
        end else if (rise[16+i]) begin
          hcnt[i] <= CW'(1);
        end else if (hcnt[i] == (first[i] ? DELAY_LAST : PERIOD_LAST)) begin
          rep[i]   <= 1'b1;
          hcnt[i]  <= '0;
          first[i] <= 1'b0;
        end else if (hcnt[i] != '1) begin
          hcnt[i] <= hcnt[i] + 1'b1;
        end
      end
    end
  end

  assign button_down = rise[20:16] | rep;
`else
  assign button_down = rise[20:16];
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: table of single-hold scenarios plus bounce, pill train,
// reset-during-debounce and long-hold sequences.
module tb_input_debouncer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] keyboard;
  logic [4:0]  button;
  logic        pill;
  logic [15:0] keyboard_down;
  logic [4:0]  button_down;
  logic        pill_pulse;

  input_debouncer #(
    .DEBOUNCE_CYCLES(20),
    .PILL_FILTER_CYCLES(3),
    .REPEAT_DELAY(500),
    .REPEAT_PERIOD(100)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .keyboard(keyboard),
    .button(button),
    .pill(pill),
    .keyboard_down(keyboard_down),
    .button_down(button_down),
    .pill_pulse(pill_pulse)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int kb_cnt, kb_first, kb_val;
  int bt_cnt, bt_first, bt_val;
  int pl_cnt, pl_first;
  int bt_at [8];

  typedef struct {
    string       name;
    logic [15:0] key;
    logic [4:0]  btn;
    logic        pl;
    int          dur;
    int          kb_n, kb_at;
    int          bt_n, bt_at;
    int          pl_n, pl_at;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    kb_cnt = 0; kb_first = -1; kb_val = 0;
    bt_cnt = 0; bt_first = -1; bt_val = 0;
    pl_cnt = 0; pl_first = -1;
    for (int i = 0; i < 8; i++) bt_at[i] = -1;
  endtask

  // One clock: active edge, then sample on the falling edge; c is the offset of that edge.
  task automatic step(input int c);
    @(posedge clock);
    @(negedge clock);
    if (keyboard_down != 16'h0) begin
      if (kb_cnt == 0) begin kb_first = c; kb_val = int'(keyboard_down); end
      kb_cnt++;
    end
    if (button_down != 5'h0) begin
      if (bt_cnt == 0) begin bt_first = c; bt_val = int'(button_down); end
      if (bt_cnt < 8) bt_at[bt_cnt] = c;
      bt_cnt++;
    end
    if (pill_pulse) begin
      if (pl_cnt == 0) pl_first = c;
      pl_cnt++;
    end
  endtask

  initial begin
    vecs[0] = '{"key5_40",  16'h0020, 5'h00, 1'b0, 40, 1, 22, 0, 0,  0, 0};
    vecs[1] = '{"key2_19",  16'h0004, 5'h00, 1'b0, 19, 0, 0,  0, 0,  0, 0};
    vecs[2] = '{"key2_20",  16'h0004, 5'h00, 1'b0, 20, 1, 22, 0, 0,  0, 0};
    vecs[3] = '{"multi",    16'h8001, 5'h01, 1'b0, 30, 1, 22, 1, 22, 0, 0};
    vecs[4] = '{"btn4_20",  16'h0000, 5'h10, 1'b0, 20, 0, 0,  1, 22, 0, 0};
    vecs[5] = '{"pill_2",   16'h0000, 5'h00, 1'b1, 2,  0, 0,  0, 0,  0, 0};
    vecs[6] = '{"pill_3",   16'h0000, 5'h00, 1'b1, 3,  0, 0,  0, 0,  1, 5};
    vecs[7] = '{"pill_4",   16'h0000, 5'h00, 1'b1, 4,  0, 0,  0, 0,  1, 5};
    vecs[8] = '{"all_30",   16'hFFFF, 5'h1F, 1'b1, 30, 1, 22, 1, 22, 1, 5};

    reset_n  = 1'b0;
    keyboard = '0;
    button   = '0;
    pill     = 1'b0;
    #1;
    check("reset_kb",   int'(keyboard_down), 0);
    check("reset_btn",  int'(button_down),   0);
    check("reset_pill", int'(pill_pulse),    0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Table-driven single-hold scenarios
    for (int v = 0; v < 9; v++) begin
      clear_obs();
      keyboard = vecs[v].key;
      button   = vecs[v].btn;
      pill     = vecs[v].pl;
      for (int c = 0; c < vecs[v].dur + 45; c++) begin
        step(c);
        if (c == vecs[v].dur - 1) begin
          keyboard = '0;
          button   = '0;
          pill     = 1'b0;
        end
      end
      check({vecs[v].name, "_kb_n"},  kb_cnt, vecs[v].kb_n);
      check({vecs[v].name, "_kb_v"},  kb_val, (vecs[v].kb_n > 0) ? int'(vecs[v].key) : 0);
      check({vecs[v].name, "_bt_n"},  bt_cnt, vecs[v].bt_n);
      check({vecs[v].name, "_bt_v"},  bt_val, (vecs[v].bt_n > 0) ? int'(vecs[v].btn) : 0);
      check({vecs[v].name, "_pl_n"},  pl_cnt, vecs[v].pl_n);
      if (vecs[v].kb_n > 0) check({vecs[v].name, "_kb_at"}, kb_first, vecs[v].kb_at);
      if (vecs[v].bt_n > 0) check({vecs[v].name, "_bt_at"}, bt_first, vecs[v].bt_at);
      if (vecs[v].pl_n > 0) check({vecs[v].name, "_pl_at"}, pl_first, vecs[v].pl_at);
    end

    // button[3] bounce: high 5, low 2, high 5, low 3, then held 30 from offset 15
    clear_obs();
    for (int c = 0; c < 90; c++) begin
      button = (c < 5 || (c >= 7 && c < 12) || (c >= 15 && c < 45)) ? 5'h08 : 5'h00;
      step(c);
    end
    button = '0;
    check("bounce_n",  bt_cnt,   1);
    check("bounce_at", bt_first, 37);
    check("bounce_v",  bt_val,   8);

    // Ten 6-cycle pills spaced 6 cycles apart
    clear_obs();
    for (int c = 0; c < 140; c++) begin
      pill = (c < 120) && ((c % 12) < 6);
      step(c);
    end
    pill = 1'b0;
    check("pill_train_n",  pl_cnt,   10);
    check("pill_train_at", pl_first, 5);

    // keyboard[2] held through a one-cycle reset pulse mid-debounce
    clear_obs();
    keyboard = 16'h0004;
    for (int c = 0; c < 15; c++) step(c);
    check("rst_mid_pre_n", kb_cnt, 0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_kb",   int'(keyboard_down), 0);
    check("rst_mid_btn",  int'(button_down),   0);
    check("rst_mid_pill", int'(pill_pulse),    0);
    @(negedge clock);
    reset_n = 1'b1;
    clear_obs();
    for (int c = 0; c < 40; c++) step(c);
    check("rst_mid_n",  kb_cnt,   1);
    check("rst_mid_at", kb_first, 22);
    check("rst_mid_v",  kb_val,   4);
    keyboard = '0;
    for (int c = 40; c < 80; c++) step(c);
    check("rst_mid_release_n", kb_cnt, 1);

    // button[1] held 800 cycles
    clear_obs();
    button = 5'h02;
    for (int c = 0; c < 860; c++) begin
      step(c);
      if (c == 799) button = '0;
    end
    check("hold_at0", bt_at[0], 22);
    check("hold_v",   bt_val,   2);
    check("kb_quiet", kb_cnt,   0);
`ifdef BUTTON_AUTO_REPEAT_EN
    check("hold_n",   bt_cnt,   4);
    check("hold_at1", bt_at[1], 522);
    check("hold_at2", bt_at[2], 622);
    check("hold_at3", bt_at[3], 722);
`else
    check("hold_n",   bt_cnt,   1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
